branch_predict_ctrl: RTL and testbench
======================================

Name: branch_predict_ctrl

Overview:
- Branch prediction and redirect controller for the RV32IM pipeline.
- IF side: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters supplies a next-PC prediction to the IF stage.
- EX side: compares the resolved branch decision and target from the EX branch unit against the prediction carried down the pipe. On mismatch it issues a one-cycle registered redirect and pipeline flush, then updates the table.

Parameters:
- IDX_BITS, 4, log2 of BTB entries (16 entries); index = pc[IDX_BITS+1:2], tag = pc[31:IDX_BITS+2].

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- if_pc  input  32  PC being fetched.
- pred_taken  output  1  combinational: BTB hit and counter[1]==1.
- pred_target  output  32  combinational: BTB target if pred_taken, else if_pc+4.
- ex_valid  input  1  EX holds a resolved branch/JAL/JALR.
- ex_pc  input  32  PC of the EX instruction.
- ex_taken  input  1  resolved direction (1 for JAL/JALR).
- ex_target  input  32  resolved target address.
- ex_pred_taken  input  1  prediction made for this instruction at IF.
- ex_pred_target  input  32  predicted next PC made at IF.
- stall  input  1  pipeline stall; EX instruction will be re-presented.
- redirect  output  1  registered; IF must load redirect_pc.
- redirect_pc  output  32  registered corrected next PC.
- flush  output  1  registered; squash IF/ID and ID/EX contents.
- resolved_cnt  output  32  statistics (optional feature).
- mispredict_cnt  output  32  statistics (optional feature).

Behaviour:
- Clock and reset: single clock CLK; RESET is synchronous, active-high.
- Reset values: redirect=0, flush=0, redirect_pc=0, stat counters=0, FSM=NORMAL, all BTB valid bits=0, all counters=2'b01. Tags and targets are don't-care. Reset mid-REDIRECT returns to NORMAL with outputs 0 after that edge.
- Lookup: purely combinational from if_pc. A write in cycle N becomes visible to lookup in cycle N+1 (read-old-data).
- Resolve qualifier: accept = ex_valid & ~stall & (state==NORMAL).
- Correct next PC: cnpc = ex_taken ? ex_target : ex_pc+4.
- Mispredict condition: accept & (cnpc != ex_pred_target). This covers direction mismatch and wrong target, including JALR.
- FSM states:
  - NORMAL:
    - On mispredict → REDIRECT; at that edge set redirect=1, flush=1, redirect_pc=cnpc.
    - Otherwise stay; redirect=flush=0.
  - REDIRECT:
    - Lasts exactly one cycle, independent of stall and ex_valid.
    - The EX instruction in this cycle is wrong-path: ignored, no table update.
    - Next edge → NORMAL; redirect=flush=0.
- Latency: mispredict detected in cycle N; redirect/flush high during cycle N+1 only.
- Table update on accept, to entry idx(ex_pc):
  - Hit (valid & tag match):
    - counter increments saturating at 3 if ex_taken, else decrements saturating at 0.
    - target = ex_target when ex_taken.
  - Miss & ex_taken: allocate with valid=1, tag, target=ex_target, counter=2'b10; replaces any occupant.
  - Miss & ~ex_taken: no change.
- Stall: while stall=1 in NORMAL there is no update and no redirect. The held instruction is evaluated once when stall drops.
- Arithmetic: pc+4 wraps modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - resolved_cnt increments on each accept.
  - mispredict_cnt increments on each mispredict.
  - Both saturate at 0xFFFFFFFF and clear on RESET.
- Undefined: counters are not built; both ports are tied to 0, so the interface is unchanged.

Test Plan:
- Reset then if_pc=0x100 → pred_taken=0, pred_target=0x104; redirect=flush=0.
- Cold miss: ex_valid=1, ex_pc=0x100, ex_taken=1, ex_target=0x200, ex_pred_target=0x104 → next cycle redirect=1, flush=1, redirect_pc=0x200 for exactly one cycle. Afterwards if_pc=0x100 gives pred_taken=1, pred_target=0x200.
- Correct prediction: same branch again with ex_pred_target=0x200 → no redirect; counter 2→3. Then two not-taken resolutions → first mispredicts (redirect_pc=0x104) and counter 3→2; second (now predicted taken with counter 2, still mispredicts) counter 2→1, so if_pc=0x100 then gives pred_taken=0.
- Wrong-path suppression: mispredict in cycle N, with ex_valid=1 and a mispredicting instruction in cycle N+1 → no second redirect and no table write for it.
- Stall: mispredicting branch held with stall=1 for 3 cycles → no redirect. Stall drops → single redirect one cycle later.
- Aliasing/wrap: taken branch at 0x140 (same index as 0x100, different tag) evicts 0x100 entry, so if_pc=0x100 gives pred_taken=0. ex_pc=0xFFFFFFFC not-taken with predicted-taken target 0x10 → redirect_pc=0x00000000. With BP_STATS_EN defined, verify counter values after each step.

Source files
------------

// File: rtl/branch_predict_ctrl_if.sv
// Predictor <-> pipeline bundle: IF lookup, EX resolve, redirect/flush.
// Stats ports are present in every build; they read 0 unless BP_STATS_EN.
interface branch_predict_ctrl_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] resolved_cnt;
  logic [31:0] mispredict_cnt;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_taken, ex_target,
    output ex_pred_taken, ex_pred_target, stall,
    input  pred_taken, pred_target, redirect, redirect_pc, flush,
    input  resolved_cnt, mispredict_cnt
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_taken, ex_target,
    input  ex_pred_taken, ex_pred_target, stall,
    output pred_taken, pred_target, redirect, redirect_pc, flush,
    output resolved_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BTB with 2-bit counters plus EX-side redirect FSM.
// Optional statistics counters built when BP_STATS_EN is defined.
module branch_predict_ctrl #(
  parameter int IDX_BITS = 4
) (
  input logic CLK,
  input logic RESET,
  branch_predict_ctrl_if.slave bp
);

  localparam int N     = 1 << IDX_BITS;
  localparam int TAG_W = 30 - IDX_BITS;

  typedef enum logic {NORMAL, REDIRECT} state_t;

  state_t             state_q, state_d;
  logic               redirect_q, redirect_d;
  logic               flush_q, flush_d;
  logic [31:0]        rpc_q, rpc_d;

  logic [N-1:0]       valid_q;
  logic [1:0]         cnt_q [N];
  logic [TAG_W-1:0]   tag_q [N];
  logic [31:0]        tgt_q [N];

  logic [IDX_BITS-1:0] lk_idx, ex_idx;
  logic [TAG_W-1:0]    lk_tag, ex_tag;
  logic                lk_hit, ex_hit;
  logic [1:0]          ex_cnt;
  logic [31:0]         cnpc;
  logic                accept, mispredict;

  logic                wr_cnt_en, wr_tgt_en, wr_alloc;
  logic [1:0]          wr_cnt;

  assign lk_idx = bp.if_pc[IDX_BITS+1:2];
  assign lk_tag = bp.if_pc[31:IDX_BITS+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign bp.pred_taken  = lk_hit & cnt_q[lk_idx][1];
  assign bp.pred_target = bp.pred_taken ? tgt_q[lk_idx]
                                        : bp.if_pc + 32'd4;

  assign ex_idx = bp.ex_pc[IDX_BITS+1:2];
  assign ex_tag = bp.ex_pc[31:IDX_BITS+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_cnt = cnt_q[ex_idx];

  assign cnpc = bp.ex_taken ? bp.ex_target : bp.ex_pc + 32'd4;
  assign accept = bp.ex_valid & ~bp.stall & (state_q == NORMAL);
  // Target compare alone also catches direction and JALR target errors
  assign mispredict = accept & (cnpc != bp.ex_pred_target);

  always_comb begin
    state_d    = state_q;
    redirect_d = 1'b0;
    flush_d    = 1'b0;
    rpc_d      = rpc_q;
    unique case (state_q)
      NORMAL: begin
        if (mispredict) begin
          state_d    = REDIRECT;
          redirect_d = 1'b1;
          flush_d    = 1'b1;
          rpc_d      = cnpc;
        end
      end
      REDIRECT: state_d = NORMAL;
      default:  state_d = NORMAL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= NORMAL;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      rpc_q      <= '0;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
      rpc_q      <= rpc_d;
    end
  end

  assign bp.redirect    = redirect_q;
  assign bp.flush       = flush_q;
  assign bp.redirect_pc = rpc_q;

  always_comb begin
    wr_cnt_en = 1'b0;
    wr_tgt_en = 1'b0;
    wr_alloc  = 1'b0;
    wr_cnt    = ex_cnt;
    if (accept) begin
      if (ex_hit) begin
        wr_cnt_en = 1'b1;
        if (bp.ex_taken) begin
          wr_tgt_en = 1'b1;
          wr_cnt    = (ex_cnt == 2'd3) ? 2'd3 : ex_cnt + 2'd1;
        end else begin
          wr_cnt    = (ex_cnt == 2'd0) ? 2'd0 : ex_cnt - 2'd1;
        end
      end else if (bp.ex_taken) begin
        wr_alloc  = 1'b1;
        wr_cnt_en = 1'b1;
        wr_tgt_en = 1'b1;
        wr_cnt    = 2'b10;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= 2'b01;
    end else begin
      if (wr_alloc)  valid_q[ex_idx] <= 1'b1;
      if (wr_cnt_en) cnt_q[ex_idx]   <= wr_cnt;
    end
  end

  // Tags and targets are qualified by valid, so they need no reset
  always_ff @(posedge CLK) begin
    if (wr_alloc)  tag_q[ex_idx] <= ex_tag;
    if (wr_tgt_en) tgt_q[ex_idx] <= bp.ex_target;
  end

`ifdef BP_STATS_EN
  logic [31:0] res_q, res_d;
  logic [31:0] mis_q, mis_d;

  always_comb begin
    res_d = res_q;
    mis_d = mis_q;
    if (accept && res_q != 32'hFFFF_FFFF)     res_d = res_q + 32'd1;
    if (mispredict && mis_q != 32'hFFFF_FFFF) mis_d = mis_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      res_q <= '0;
      mis_q <= '0;
    end else begin
      res_q <= res_d;
      mis_q <= mis_d;
    end
  end

  assign bp.resolved_cnt   = res_q;
  assign bp.mispredict_cnt = mis_q;
`else
  assign bp.resolved_cnt   = '0;
  assign bp.mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl; stats checks follow BP_STATS_EN.
module tb_branch_predict_ctrl;

  logic CLK = 1'b0;
  logic RESET;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  branch_predict_ctrl_if bp ();

  branch_predict_ctrl #(.IDX_BITS(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bp    (bp.slave)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic r,
                         input logic f, input logic [31:0] pc);
    chk({tag, ".redirect"}, {31'd0, bp.redirect}, {31'd0, r});
    chk({tag, ".flush"}, {31'd0, bp.flush}, {31'd0, f});
    chk({tag, ".redirect_pc"}, bp.redirect_pc, pc);
  endtask

  task automatic chk_pred(input string tag, input logic [31:0] pc,
                          input logic t, input logic [31:0] tgt);
    bp.if_pc = pc;
    #1;
    chk({tag, ".pred_taken"}, {31'd0, bp.pred_taken}, {31'd0, t});
    chk({tag, ".pred_target"}, bp.pred_target, tgt);
  endtask

  task automatic chk_stats(input string tag, input int r, input int m);
`ifdef BP_STATS_EN
    chk({tag, ".resolved"}, bp.resolved_cnt, r);
    chk({tag, ".mispred"}, bp.mispredict_cnt, m);
`else
    chk({tag, ".resolved"}, bp.resolved_cnt, 32'd0);
    chk({tag, ".mispred"}, bp.mispredict_cnt, 32'd0);
`endif
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc,
                        input logic t, input logic [31:0] tgt,
                        input logic pt, input logic [31:0] ptgt);
    bp.ex_valid       = v;
    bp.ex_pc          = pc;
    bp.ex_taken       = t;
    bp.ex_target      = tgt;
    bp.ex_pred_taken  = pt;
    bp.ex_pred_target = ptgt;
  endtask

  initial begin
    RESET    = 1'b1;
    bp.if_pc = 32'h100;
    bp.stall = 1'b0;
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    RESET = 1'b0;

    chk_out("reset", 1'b0, 1'b0, 32'h0);
    chk_pred("reset", 32'h100, 1'b0, 32'h104);
    chk_stats("reset", 0, 0);

    // cold miss, taken: allocate and redirect
    set_ex(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    tick();
    chk_out("cold", 1'b1, 1'b1, 32'h200);
    bp.ex_valid = 1'b0;
    chk_pred("cold", 32'h100, 1'b1, 32'h200);
    tick();
    chk_out("cold_1cyc", 1'b0, 1'b0, 32'h200);
    chk_stats("cold", 1, 1);

    // correct prediction, counter 2->3
    set_ex(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    tick();
    chk_out("correct", 1'b0, 1'b0, 32'h200);
    // not-taken, counter 3->2
    set_ex(1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    tick();
    chk_out("nt1", 1'b1, 1'b1, 32'h104);
    bp.ex_valid = 1'b0;
    tick();
    chk_out("nt1_1cyc", 1'b0, 1'b0, 32'h104);
    chk_pred("nt1", 32'h100, 1'b1, 32'h200);
    // not-taken again, counter 2->1
    bp.ex_valid = 1'b1;
    tick();
    chk_out("nt2", 1'b1, 1'b1, 32'h104);
    bp.ex_valid = 1'b0;
    tick();
    chk_pred("nt2", 32'h100, 1'b0, 32'h104);
    chk_stats("nt2", 4, 3);

    // wrong-path instruction during REDIRECT must be ignored
    set_ex(1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 32'h104);
    tick();
    chk_out("wp", 1'b1, 1'b1, 32'h300);
    set_ex(1'b1, 32'h104, 1'b1, 32'h400, 1'b0, 32'h108);
    tick();
    chk_out("wp_ign", 1'b0, 1'b0, 32'h300);
    bp.ex_valid = 1'b0;
    chk_pred("wp_nowr", 32'h104, 1'b0, 32'h108);
    chk_pred("wp_upd", 32'h100, 1'b1, 32'h300);
    chk_stats("wp", 5, 4);

    // stall holds a mispredicting branch for 3 cycles
    set_ex(1'b1, 32'h104, 1'b1, 32'h400, 1'b0, 32'h108);
    bp.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall", 1'b0, 1'b0, 32'h300);
    end
    chk_pred("stall", 32'h104, 1'b0, 32'h108);
    bp.stall = 1'b0;
    tick();
    chk_out("unstall", 1'b1, 1'b1, 32'h400);
    bp.ex_valid = 1'b0;
    tick();
    chk_out("unstall_1cyc", 1'b0, 1'b0, 32'h400);
    chk_pred("unstall", 32'h104, 1'b1, 32'h400);
    chk_stats("stall", 6, 5);

    // alias at same index evicts 0x100
    set_ex(1'b1, 32'h140, 1'b1, 32'h500, 1'b0, 32'h144);
    tick();
    chk_out("alias", 1'b1, 1'b1, 32'h500);
    bp.ex_valid = 1'b0;
    tick();
    chk_pred("alias_old", 32'h100, 1'b0, 32'h104);
    chk_pred("alias_new", 32'h140, 1'b1, 32'h500);
    chk_stats("alias", 7, 6);

    // pc+4 wraps to zero
    set_ex(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 32'h10);
    tick();
    chk_out("wrap", 1'b1, 1'b1, 32'h0);
    bp.ex_valid = 1'b0;
    tick();
    chk_pred("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    chk_stats("wrap", 8, 7);

    // reset asserted during REDIRECT
    set_ex(1'b1, 32'h140, 1'b0, 32'h500, 1'b1, 32'h500);
    tick();
    chk_out("pre_rst", 1'b1, 1'b1, 32'h144);
    bp.ex_valid = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk_out("mid_rst", 1'b0, 1'b0, 32'h0);
    chk_pred("mid_rst", 32'h140, 1'b0, 32'h144);
    chk_stats("mid_rst", 0, 0);
    tick();
    chk_out("post_rst", 1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
